// File: rtl/accel_poll_ctrl.sv
// accel_poll_ctrl: runs the accelerometer register bring-up, then periodically reads all axes and flags stillness.
// Latency: each frame/go is registered one edge after the decision; oDATA/oVALID/oSTILL* update on the edge that samples iSPI_END.
// Backpressure: one transaction in flight; waits for iSPI_END (bounded by TIMEOUT, then restarts bring-up) before the next go.
module accel_poll_ctrl #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned NUM_AXES     = 3,
    parameter int unsigned INI_NUMBER   = 11,
    parameter logic [INI_NUMBER*14-1:0] INIT_TABLE = {
        6'h2D, 8'h08,  6'h31, 8'h08,  6'h2F, 8'h10,  6'h2E, 8'h10,
        6'h2C, 8'h09,  6'h29, 8'h46,  6'h28, 8'h09,  6'h27, 8'h7F,
        6'h26, 8'h01,  6'h25, 8'h03,  6'h24, 8'h20
    },
    parameter int unsigned POLL_PERIOD  = 200000,
    parameter int unsigned STILL_THRESH = 8,
    parameter int unsigned STILL_COUNT  = 5,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic                         iSPI_CLK,
    input  logic                         iRSTN,
    output logic [15:0]                  oP2S_DATA,
    output logic                         oSPI_GO,
    input  logic                         iSPI_END,
    input  logic [NUM_AXES*DATA_W-1:0]   iS2P_DATA,
    output logic [NUM_AXES*DATA_W-1:0]   oDATA,
    output logic                         oVALID,
    output logic                         oSTILL,
    output logic [NUM_AXES-1:0]          oSTILL_AXIS,
    output logic                         oINIT_DONE,
    output logic [7:0]                   oERR_CNT
);

    localparam int IDX_W  = (INI_NUMBER > 1) ? $clog2(INI_NUMBER) : 1;
    localparam int TBL_N  = 2 ** IDX_W;
    localparam int POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(INI_NUMBER - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);
    localparam logic [POLL_W-1:0] POLL_ONE  = POLL_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [7:0]        STILL_MAX = 8'(STILL_COUNT);
    localparam logic [DATA_W:0]   THRESH    = (DATA_W + 1)'(STILL_THRESH);

    // Frame = {mode[1:0], addr[5:0], data[7:0]}
    localparam logic [1:0]  MODE_WR    = 2'b00;
    localparam logic [15:0] READ_FRAME = {2'b11, 6'h32, 8'h00};

    typedef enum logic [1:0] {
        S_INIT_LOAD,
        S_INIT_WAIT,
        S_POLL_WAIT,
        S_READ_WAIT
    } state_t;

    state_t                       state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [POLL_W-1:0]            poll_cnt_q;
    logic [TMO_W-1:0]             tmo_q;
    logic [7:0]                   still_cnt_q;
    logic [NUM_AXES*DATA_W-1:0]   prev_q;
    logic                         prev_valid_q;
    logic [15:0]                  p2s_q;
    logic                         go_q;
    logic [NUM_AXES*DATA_W-1:0]   data_q;
    logic                         valid_q;
    logic                         still_q;
    logic [NUM_AXES-1:0]          still_axis_q;
    logic                         init_done_q;
    logic [7:0]                   err_cnt_q;

    logic [NUM_AXES-1:0]          still_axis_d;
    logic [7:0]                   still_cnt_d;
    logic                         wd_fire;

    // Bring-up table unpacked into a power-of-two array so the index never runs off the end
    logic [13:0] tbl [TBL_N];
    for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
        if (g < INI_NUMBER) begin : g_used
            assign tbl[g] = INIT_TABLE[g*14 +: 14];
        end else begin : g_pad
            assign tbl[g] = 14'h0;
        end
    end

    // |now - prev| evaluated one bit wider than a sample so opposite-sign extremes cannot wrap
    function automatic logic [DATA_W:0] abs_delta(input logic [DATA_W-1:0] now_v,
                                                  input logic [DATA_W-1:0] old_v);
        logic [DATA_W:0] d;
        d = {now_v[DATA_W-1], now_v} - {old_v[DATA_W-1], old_v};
        return d[DATA_W] ? -d : d;
    endfunction

    // Per-axis stillness of the incoming sample against the previous one; never still without history
    always_comb begin
        still_axis_d = '0;
        for (int a = 0; a < NUM_AXES; a++) begin
            still_axis_d[a] = prev_valid_q &&
                (abs_delta(iS2P_DATA[a*DATA_W +: DATA_W], prev_q[a*DATA_W +: DATA_W]) <= THRESH);
        end
    end

    // Consecutive all-axes-still count, saturating so oSTILL stays up while the device rests
    always_comb begin
        still_cnt_d = 8'd0;
        if (prev_valid_q && (&still_axis_d)) begin
            still_cnt_d = (still_cnt_q == STILL_MAX) ? still_cnt_q : still_cnt_q + 8'd1;
        end
    end

    // A completion seen on the last allowed cycle wins over the watchdog
    assign wd_fire = ((state_q == S_INIT_WAIT) || (state_q == S_READ_WAIT)) &&
                     !iSPI_END && (tmo_q == TMO_LAST);

    // Controller FSM with all outputs registered
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q      <= S_INIT_LOAD;
            idx_q        <= '0;
            poll_cnt_q   <= '0;
            tmo_q        <= '0;
            still_cnt_q  <= 8'd0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            p2s_q        <= 16'h0;
            go_q         <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            still_q      <= 1'b0;
            still_axis_q <= '0;
            init_done_q  <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            go_q    <= 1'b0;
            valid_q <= 1'b0;
            if (wd_fire) begin
                // Hung transport: count it and restart bring-up from scratch; oDATA is kept
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
                idx_q        <= '0;
                tmo_q        <= '0;
                init_done_q  <= 1'b0;
                prev_valid_q <= 1'b0;
                still_cnt_q  <= 8'd0;
                still_q      <= 1'b0;
                still_axis_q <= '0;
                state_q      <= S_INIT_LOAD;
            end else begin
                case (state_q)
                    S_INIT_LOAD: begin
                        p2s_q   <= {MODE_WR, tbl[idx_q]};
                        go_q    <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_INIT_WAIT;
                    end
                    S_INIT_WAIT: begin
                        if (iSPI_END) begin
                            tmo_q <= '0;
                            idx_q <= idx_q + IDX_ONE;
                            if (idx_q == IDX_LAST) begin
                                init_done_q <= 1'b1;
                                poll_cnt_q  <= '0;
                                state_q     <= S_POLL_WAIT;
                            end else begin
                                state_q <= S_INIT_LOAD;
                            end
                        end else begin
                            tmo_q <= tmo_q + TMO_ONE;
                        end
                    end
                    S_POLL_WAIT: begin
                        if (poll_cnt_q == POLL_LAST) begin
                            poll_cnt_q <= '0;
                            p2s_q      <= READ_FRAME;
                            go_q       <= 1'b1;
                            tmo_q      <= '0;
                            state_q    <= S_READ_WAIT;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + POLL_ONE;
                        end
                    end
                    S_READ_WAIT: begin
                        if (iSPI_END) begin
                            data_q       <= iS2P_DATA;
                            valid_q      <= 1'b1;
                            still_axis_q <= still_axis_d;
                            still_cnt_q  <= still_cnt_d;
                            still_q      <= (still_cnt_d == STILL_MAX);
                            prev_q       <= iS2P_DATA;
                            prev_valid_q <= 1'b1;
                            tmo_q        <= '0;
                            state_q      <= S_POLL_WAIT;
                        end else begin
                            tmo_q <= tmo_q + TMO_ONE;
                        end
                    end
                    default: begin
                        state_q <= S_INIT_LOAD;
                    end
                endcase
            end
        end
    end

    assign oP2S_DATA   = p2s_q;
    assign oSPI_GO     = go_q;
    assign oDATA       = data_q;
    assign oVALID      = valid_q;
    assign oSTILL      = still_q;
    assign oSTILL_AXIS = still_axis_q;
    assign oINIT_DONE  = init_done_q;
    assign oERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_accel_poll_ctrl.sv
// tb_accel_poll_ctrl: directed bench for accel_poll_ctrl with a delay-programmable transport responder.
// Latency: observes outputs 1 time unit after each rising edge; the responder drives iSPI_END on falling edges.
// Backpressure: responder answers each go after resp_delay wait cycles, or never when resp_en is low.
module tb_accel_poll_ctrl;

    localparam int DW = 16;
    localparam int NA = 3;
    localparam int PP = 50;
    localparam int TO = 64;

    localparam int W_GO    = 0;
    localparam int W_VALID = 1;
    localparam int W_DONE  = 2;

    logic              iSPI_CLK;
    logic              iRSTN;
    logic [15:0]       oP2S_DATA;
    logic              oSPI_GO;
    logic              iSPI_END;
    logic [NA*DW-1:0]  iS2P_DATA;
    logic [NA*DW-1:0]  oDATA;
    logic              oVALID;
    logic              oSTILL;
    logic [NA-1:0]     oSTILL_AXIS;
    logic              oINIT_DONE;
    logic [7:0]        oERR_CNT;

    int total;
    int bad;

    bit  resp_en;
    int  resp_delay;
    int  resp_cnt;
    bit  prev_go;
    int  go_dbl;
    logic [15:0] frames [$];
    logic [15:0] exp_init [11];

    accel_poll_ctrl #(
        .DATA_W       (DW),
        .NUM_AXES     (NA),
        .POLL_PERIOD  (PP),
        .STILL_THRESH (8),
        .STILL_COUNT  (3),
        .TIMEOUT      (TO)
    ) dut (
        .iSPI_CLK    (iSPI_CLK),
        .iRSTN       (iRSTN),
        .oP2S_DATA   (oP2S_DATA),
        .oSPI_GO     (oSPI_GO),
        .iSPI_END    (iSPI_END),
        .iS2P_DATA   (iS2P_DATA),
        .oDATA       (oDATA),
        .oVALID      (oVALID),
        .oSTILL      (oSTILL),
        .oSTILL_AXIS (oSTILL_AXIS),
        .oINIT_DONE  (oINIT_DONE),
        .oERR_CNT    (oERR_CNT)
    );

    initial iSPI_CLK = 1'b0;
    always #5 iSPI_CLK = ~iSPI_CLK;

    // Transport model: logs every frame at go, answers resp_delay falling edges later
    initial begin
        iSPI_END = 1'b0;
        resp_cnt = 0;
        prev_go  = 1'b0;
        go_dbl   = 0;
        forever begin
            @(negedge iSPI_CLK);
            iSPI_END = 1'b0;
            if (oSPI_GO === 1'b1) begin
                frames.push_back(oP2S_DATA);
                if (prev_go) go_dbl++;
                resp_cnt = resp_en ? resp_delay : 0;
            end else if (!resp_en) begin
                resp_cnt = 0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) iSPI_END = 1'b1;
            end
            prev_go = (oSPI_GO === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, required to finish earlier", $time);
        $fatal(1, "bench stopped");
    end

    task automatic wait_sig(input int which, input int budget, output int cyc, output bit ok);
        logic s;
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < budget) begin
            @(posedge iSPI_CLK); #1;
            cyc++;
            case (which)
                W_GO:    s = oSPI_GO;
                W_VALID: s = oVALID;
                default: s = oINIT_DONE;
            endcase
            if (s === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic run_sample(input logic [NA*DW-1:0] d, output bit ok);
        int cyc;
        iS2P_DATA = d;
        wait_sig(W_VALID, 200, cyc, ok);
    endtask

    task automatic test_reset();
        iRSTN = 1'b0;
        repeat (3) @(posedge iSPI_CLK);
        #1;
        total++;
        if ({oSPI_GO, oVALID, oSTILL, oINIT_DONE} !== 4'b0000) begin
            $display("FAIL reset_flags: got go/valid/still/done=%b expected 0000", {oSPI_GO, oVALID, oSTILL, oINIT_DONE});
            bad++;
        end
        total++;
        if (oP2S_DATA !== 16'h0000) begin
            $display("FAIL reset_frame: got %h expected 0000", oP2S_DATA);
            bad++;
        end
        total++;
        if (oDATA !== '0) begin
            $display("FAIL reset_data: got %h expected 0", oDATA);
            bad++;
        end
        total++;
        if ({oSTILL_AXIS, oERR_CNT} !== 11'h000) begin
            $display("FAIL reset_axis_err: got axis=%b err=%0d expected 0/0", oSTILL_AXIS, oERR_CNT);
            bad++;
        end
    endtask

    task automatic test_init();
        int ends;
        int cyc;
        logic [15:0] got;
        resp_en    = 1'b1;
        resp_delay = 9;
        frames.delete();
        @(negedge iSPI_CLK);
        iRSTN = 1'b1;
        ends = 0;
        cyc  = 0;
        while (ends < 11 && cyc < 400) begin
            @(posedge iSPI_CLK); #1;
            cyc++;
            if (iSPI_END === 1'b1) begin
                ends++;
                if (ends == 10) begin
                    total++;
                    if (oINIT_DONE !== 1'b0) begin
                        $display("FAIL init_done_early: got %b after 10th end, expected 0", oINIT_DONE);
                        bad++;
                    end
                end
                if (ends == 11) begin
                    total++;
                    if (oINIT_DONE !== 1'b1) begin
                        $display("FAIL init_done_rise: got %b on 11th end, expected 1", oINIT_DONE);
                        bad++;
                    end
                end
            end
        end
        total++;
        if (ends != 11) begin
            $display("FAIL init_end_count: got %0d ends in %0d cycles, expected 11", ends, cyc);
            bad++;
        end
        total++;
        if (frames.size() != 11) begin
            $display("FAIL init_frame_count: got %0d frames, expected 11", frames.size());
            bad++;
        end
        for (int i = 0; i < 11; i++) begin
            got = (i < frames.size()) ? frames[i] : 16'hxxxx;
            total++;
            if (got !== exp_init[i]) begin
                $display("FAIL init_frame[%0d]: got %h expected %h", i, got, exp_init[i]);
                bad++;
            end
        end
    endtask

    task automatic test_poll();
        int cyc;
        bit ok;
        iS2P_DATA = 48'h0003_FFFE_0100;
        wait_sig(W_GO, 200, cyc, ok);
        total++;
        if (!ok || cyc != PP) begin
            $display("FAIL poll_first_launch: got go after %0d cycles (seen=%b), expected %0d", cyc, ok, PP);
            bad++;
        end
        total++;
        if (oP2S_DATA !== 16'hF200) begin
            $display("FAIL poll_read_frame: got %h expected F200", oP2S_DATA);
            bad++;
        end
        wait_sig(W_VALID, 200, cyc, ok);
        total++;
        if (!ok || cyc != 10) begin
            $display("FAIL poll_valid_latency: got %0d cycles (seen=%b), expected 10", cyc, ok);
            bad++;
        end
        total++;
        if (oDATA !== 48'h0003_FFFE_0100) begin
            $display("FAIL poll_data: got %h expected 0003fffe0100", oDATA);
            bad++;
        end
        total++;
        if (oSTILL_AXIS !== 3'b000 || oSTILL !== 1'b0) begin
            $display("FAIL poll_first_still: got axis=%b still=%b expected 000/0", oSTILL_AXIS, oSTILL);
            bad++;
        end
        @(posedge iSPI_CLK); #1;
        total++;
        if (oVALID !== 1'b0 || oDATA !== 48'h0003_FFFE_0100) begin
            $display("FAIL poll_valid_pulse: got valid=%b data=%h expected 0 and held data", oVALID, oDATA);
            bad++;
        end
        wait_sig(W_GO, 200, cyc, ok);
        total++;
        if (!ok || cyc != PP - 1 || oP2S_DATA !== 16'hF200) begin
            $display("FAIL poll_period: got %0d cycles frame=%h (seen=%b), expected %0d and F200", cyc, oP2S_DATA, ok, PP - 1);
            bad++;
        end
        wait_sig(W_VALID, 200, cyc, ok);
        total++;
        if (!ok || oSTILL_AXIS !== 3'b111 || oSTILL !== 1'b0) begin
            $display("FAIL poll_repeat_still: got axis=%b still=%b (seen=%b), expected 111/0", oSTILL_AXIS, oSTILL, ok);
            bad++;
        end
    endtask

    task automatic test_signed_edge();
        bit ok;
        run_sample({16'h0003, 16'hFFFE, 16'h7FFF}, ok);
        total++;
        if (!ok || oSTILL_AXIS !== 3'b110) begin
            $display("FAIL signed_pos_max: got axis=%b (seen=%b), expected 110", oSTILL_AXIS, ok);
            bad++;
        end
        run_sample({16'h0003, 16'hFFFE, 16'h8000}, ok);
        total++;
        if (!ok || oSTILL_AXIS !== 3'b110 || oSTILL !== 1'b0) begin
            $display("FAIL signed_wrap: got axis=%b still=%b (seen=%b), expected 110/0", oSTILL_AXIS, oSTILL, ok);
            bad++;
        end
    endtask

    task automatic test_still();
        logic [15:0] xs   [8] = '{16'd100, 16'd105, 16'd97, 16'd104, 16'd120, 16'd120, 16'd120, 16'd120};
        logic [2:0]  axis [8] = '{3'b110, 3'b111, 3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 3'b111};
        logic        st   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bit ok;
        for (int i = 0; i < 8; i++) begin
            run_sample({16'h0003, 16'hFFFE, xs[i]}, ok);
            total++;
            if (!ok || oSTILL_AXIS !== axis[i]) begin
                $display("FAIL still_axis[%0d]: got %b (seen=%b), expected %b", i, oSTILL_AXIS, ok, axis[i]);
                bad++;
            end
            total++;
            if (oSTILL !== st[i]) begin
                $display("FAIL still_flag[%0d]: got %b expected %b", i, oSTILL, st[i]);
                bad++;
            end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        resp_en = 1'b0;
        wait_sig(W_GO, 200, cyc, ok);
        total++;
        if (!ok) begin
            $display("FAIL timeout_read_go: no go within %0d cycles, expected one", cyc);
            bad++;
        end
        for (int k = 1; k <= 65; k++) begin
            @(posedge iSPI_CLK); #1;
            if (k == 63) begin
                total++;
                if (oERR_CNT !== 8'd0 || oINIT_DONE !== 1'b1) begin
                    $display("FAIL timeout_early: got err=%0d done=%b at 63 cycles, expected 0/1", oERR_CNT, oINIT_DONE);
                    bad++;
                end
            end
            if (k == 64) begin
                total++;
                if (oERR_CNT !== 8'd1) begin
                    $display("FAIL timeout_err: got %0d expected 1", oERR_CNT);
                    bad++;
                end
                total++;
                if ({oINIT_DONE, oSTILL, oSTILL_AXIS} !== 5'b00000) begin
                    $display("FAIL timeout_clear: got done/still/axis=%b expected 00000", {oINIT_DONE, oSTILL, oSTILL_AXIS});
                    bad++;
                end
                total++;
                if (oDATA !== {16'h0003, 16'hFFFE, 16'd120}) begin
                    $display("FAIL timeout_data_hold: got %h expected 0003fffe0078", oDATA);
                    bad++;
                end
                resp_en    = 1'b1;
                resp_delay = TO - 1;
            end
            if (k == 65) begin
                total++;
                if (oSPI_GO !== 1'b1 || oP2S_DATA !== 16'h2420) begin
                    $display("FAIL timeout_restart: got go=%b frame=%h expected 1/2420", oSPI_GO, oP2S_DATA);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_coincident();
        int cyc;
        bit ok;
        iS2P_DATA = 48'h0001_0002_0003;
        wait_sig(W_DONE, 1500, cyc, ok);
        total++;
        if (!ok || oERR_CNT !== 8'd1) begin
            $display("FAIL coinc_init: got done seen=%b err=%0d, expected 1/1", ok, oERR_CNT);
            bad++;
        end
        wait_sig(W_GO, 200, cyc, ok);
        wait_sig(W_VALID, 200, cyc, ok);
        total++;
        if (!ok || cyc != TO) begin
            $display("FAIL coinc_read_latency: got %0d cycles (seen=%b), expected %0d", cyc, ok, TO);
            bad++;
        end
        total++;
        if (oERR_CNT !== 8'd1 || oINIT_DONE !== 1'b1) begin
            $display("FAIL coinc_no_error: got err=%0d done=%b expected 1/1", oERR_CNT, oINIT_DONE);
            bad++;
        end
        total++;
        if (oDATA !== 48'h0001_0002_0003 || oSTILL_AXIS !== 3'b000) begin
            $display("FAIL coinc_sample: got data=%h axis=%b expected 000100020003/000", oDATA, oSTILL_AXIS);
            bad++;
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        bit ok;
        resp_en = 1'b0;
        wait_sig(W_GO, 200, cyc, ok);
        repeat (70) @(posedge iSPI_CLK);
        #1;
        total++;
        if (!ok || oERR_CNT !== 8'd2 || oP2S_DATA !== 16'h2420 || oINIT_DONE !== 1'b0) begin
            $display("FAIL arst_setup: got err=%0d frame=%h done=%b (go seen=%b), expected 2/2420/0", oERR_CNT, oP2S_DATA, oINIT_DONE, ok);
            bad++;
        end
        #2;
        iRSTN = 1'b0;
        #1;
        total++;
        if ({oSPI_GO, oVALID, oSTILL, oINIT_DONE, oSTILL_AXIS} !== 7'b0 || oERR_CNT !== 8'd0 ||
            oP2S_DATA !== 16'h0000 || oDATA !== '0) begin
            $display("FAIL arst_immediate: got flags=%b err=%0d frame=%h data=%h expected all 0",
                     {oSPI_GO, oVALID, oSTILL, oINIT_DONE, oSTILL_AXIS}, oERR_CNT, oP2S_DATA, oDATA);
            bad++;
        end
        repeat (2) @(negedge iSPI_CLK);
        iRSTN = 1'b1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        resp_en    = 1'b0;
        resp_delay = 9;
        iRSTN      = 1'b0;
        iS2P_DATA  = '0;
        exp_init   = '{16'h2420, 16'h2503, 16'h2601, 16'h277F, 16'h2809, 16'h2946,
                       16'h2C09, 16'h2E10, 16'h2F10, 16'h3108, 16'h2D08};
        test_reset();
        test_init();
        test_poll();
        test_signed_edge();
        test_still();
        test_timeout();
        test_coincident();
        test_async_reset();
        total++;
        if (go_dbl != 0) begin
            $display("FAIL go_spacing: got %0d back-to-back go pulses, expected 0", go_dbl);
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
